// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the boot-time program loader: FSM state encoding and
// the checksum width used by both the write-side and read-side accumulators.
// No ports (package).
// -----------------------------------------------------------------------------
package loader_pkg;

    localparam int CSUM_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_VERIFY = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

endpackage

// File: rtl/checksum8.sv
// -----------------------------------------------------------------------------
// checksum8
// 8-bit additive accumulator (mod 256) with synchronous clear and add-enable.
// Clear has priority over add.
// Ports:
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset
//   clear    in   zero the running sum on the next edge
//   add_en   in   add add_data to the running sum on the next edge
//   add_data in   byte to accumulate
//   sum      out  registered running sum
// -----------------------------------------------------------------------------
module checksum8
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              add_en,
    input  logic [CSUM_W-1:0] add_data,
    output logic [CSUM_W-1:0] sum
);

    logic [CSUM_W-1:0] sum_r;

    // Running sum register: reset, clear, accumulate or hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_r <= {CSUM_W{1'b0}};
        end else if (clear) begin
            sum_r <= {CSUM_W{1'b0}};
        end else if (add_en) begin
            sum_r <= sum_r + add_data;
        end else begin
            sum_r <= sum_r;
        end
    end

    assign sum = sum_r;

endmodule

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
// Boot-time loader in front of the 8-bit program memory. Accepts a byte
// stream over valid/ready, writes it to consecutive addresses from 0, then
// (optionally) reads the image back and compares 8-bit additive checksums.
// Holds the CPU off the memory bus while loading or verifying.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start, length         load request (sampled in IDLE/DONE/ERROR), byte count
//   in_data/valid/ready   program byte stream
//   mem_addr/data         memory address and write data
//   mem_ram_in/ram_out    memory write strobe / read enable
//   mem_q                 memory combinational read data
//   cpu_hold, busy        bus hold and activity status
//   done, error           sticky completion / verification-failure flags
// -----------------------------------------------------------------------------
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int MEM_SIZE = 1024,
    parameter bit VERIFY   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   length,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_ram_in,
    output logic              mem_ram_out,
    input  logic [7:0]        mem_q,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int LEN_W = ADDR_W + 1;

    state_t              state_r;
    state_t              state_nx_s;
    logic [LEN_W-1:0]    len_r;
    logic [LEN_W-1:0]    len_nx_s;
    logic [ADDR_W-1:0]   count_r;
    logic [ADDR_W-1:0]   count_nx_s;
    logic [LEN_W-1:0]    len_clamp_s;
    logic                idle_like_s;
    logic                start_ok_s;
    logic                accept_s;
    logic                last_s;
    logic                sum_match_s;
    logic                busy_nx_s;
    logic [CSUM_W-1:0]   sum_wr_s;
    logic [CSUM_W-1:0]   sum_rd_s;
    logic [CSUM_W-1:0]   sum_rd_tot_s;

    logic                in_ready_r;
    logic                mem_ram_out_r;
    logic                cpu_hold_r;
    logic                busy_r;
    logic                done_r;
    logic                error_r;
    logic [ADDR_W-1:0]   mem_addr_r;

    assign len_clamp_s = (length > LEN_W'(MEM_SIZE)) ? LEN_W'(MEM_SIZE) : length;
    assign idle_like_s = (state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERROR);
    assign start_ok_s  = start && idle_like_s;
    // Gating with rst_n keeps a reset asserted mid-stream from landing a write.
    assign accept_s    = in_ready_r && in_valid && rst_n;
    // len_r >= 1 whenever WRITE/VERIFY is active, so len_r-1 never underflows there.
    assign last_s      = ({1'b0, count_r} == (len_r - LEN_W'(1)));
    // The final byte read is folded in combinationally so no extra cycle is needed.
    assign sum_rd_tot_s = sum_rd_s + mem_q;
    assign sum_match_s  = (sum_rd_tot_s == sum_wr_s);

    checksum8 u_sum_wr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (start_ok_s),
        .add_en   (accept_s),
        .add_data (in_data),
        .sum      (sum_wr_s)
    );

    checksum8 u_sum_rd (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (start_ok_s),
        .add_en   (state_r == ST_VERIFY),
        .add_data (mem_q),
        .sum      (sum_rd_s)
    );

    // Next-state, length and address-counter logic.
    always_comb begin
        state_nx_s = state_r;
        len_nx_s   = len_r;
        count_nx_s = count_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    len_nx_s   = len_clamp_s;
                    count_nx_s = ADDR_W'(0);
                    state_nx_s = (len_clamp_s == LEN_W'(0)) ? ST_DONE : ST_WRITE;
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_WRITE: begin
                if (accept_s) begin
                    if (last_s) begin
                        count_nx_s = ADDR_W'(0);
                        state_nx_s = VERIFY ? ST_VERIFY : ST_DONE;
                    end else begin
                        count_nx_s = count_r + ADDR_W'(1);
                    end
                end else begin
                    count_nx_s = count_r;
                end
            end
            ST_VERIFY: begin
                if (last_s) begin
                    count_nx_s = ADDR_W'(0);
                    state_nx_s = sum_match_s ? ST_DONE : ST_ERROR;
                end else begin
                    count_nx_s = count_r + ADDR_W'(1);
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                count_nx_s = ADDR_W'(0);
            end
        endcase
    end

    assign busy_nx_s = (state_nx_s == ST_WRITE) || (state_nx_s == ST_VERIFY);

    // State, counters and output registers; outputs are decoded from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            len_r         <= LEN_W'(0);
            count_r       <= ADDR_W'(0);
            in_ready_r    <= 1'b0;
            mem_ram_out_r <= 1'b0;
            cpu_hold_r    <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            error_r       <= 1'b0;
            mem_addr_r    <= ADDR_W'(0);
        end else begin
            state_r       <= state_nx_s;
            len_r         <= len_nx_s;
            count_r       <= count_nx_s;
            in_ready_r    <= (state_nx_s == ST_WRITE);
            mem_ram_out_r <= (state_nx_s == ST_VERIFY);
            cpu_hold_r    <= busy_nx_s;
            busy_r        <= busy_nx_s;
            done_r        <= (state_nx_s == ST_DONE);
            error_r       <= (state_nx_s == ST_ERROR);
            mem_addr_r    <= busy_nx_s ? count_nx_s : ADDR_W'(0);
        end
    end

    assign in_ready    = in_ready_r;
    assign mem_addr    = mem_addr_r;
    // The memory captures the byte on the accepting edge, so data passes straight through.
    assign mem_data    = in_ready_r ? in_data : 8'h00;
    assign mem_ram_in  = accept_s;
    assign mem_ram_out = mem_ram_out_r;
    assign cpu_hold    = cpu_hold_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign error       = error_r;

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
// Directed self-checking bench for program_loader with a behavioural 1 KiB
// memory model (write on ram_in, combinational read, optional forced
// corruption of address 2 while reading back).
// -----------------------------------------------------------------------------
module tb_program_loader;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W:0]   length;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              mem_ram_in;
    logic              mem_ram_out;
    logic [7:0]        mem_q;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;

    logic [7:0]  mem [1024];
    int          wr_count = 0;
    int          wr_base;
    logic [9:0]  last_wr_addr = 10'd0;
    logic        corrupt = 1'b0;
    logic [7:0]  pat [4];
    int          checks = 0;
    int          failures = 0;
    bit          timed_out;

    wire [6:0] outs = {in_ready, mem_ram_in, mem_ram_out, cpu_hold, busy, done, error};

    program_loader #(.ADDR_W(10), .MEM_SIZE(1024), .VERIFY(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .length      (length),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_ram_in  (mem_ram_in),
        .mem_ram_out (mem_ram_out),
        .mem_q       (mem_q),
        .cpu_hold    (cpu_hold),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    // Memory model write port and write monitor.
    always @(posedge clk) begin
        if (mem_ram_in === 1'b1) begin
            mem[mem_addr] <= mem_data;
            wr_count      <= wr_count + 1;
            last_wr_addr  <= mem_addr;
        end
    end

    assign mem_q = (corrupt && mem_ram_out && (mem_addr == 10'd2)) ? 8'h00 : mem[mem_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_end(input int max_cycles, output bit to);
        int n;
        n = 0;
        while (!(done === 1'b1 || error === 1'b1) && n < max_cycles) begin
            tick();
            n++;
        end
        to = !(done === 1'b1 || error === 1'b1);
    endtask

    // Four-byte back-to-back load of pat[], checking exact done/error timing.
    task automatic load4(input logic [6:0] exp_end, input string tag);
        start = 1'b1; length = 11'd4; in_valid = 1'b0;
        tick();
        start = 1'b0;
        check({tag, " write_outs"}, 32'(outs), 32'(7'b1001100));
        for (int i = 0; i < 4; i++) begin
            in_data = pat[i]; in_valid = 1'b1;
            #1;
            check({tag, " ram_in"}, 32'(mem_ram_in), 32'd1);
            check({tag, " addr"}, 32'(mem_addr), 32'(i));
            check({tag, " data"}, 32'(mem_data), 32'(pat[i]));
            tick();
        end
        in_valid = 1'b0;
        #1;
        check({tag, " verify_outs"}, 32'(outs), 32'(7'b0011100));
        check({tag, " verify_addr0"}, 32'(mem_addr), 32'd0);
        for (int j = 1; j <= 4; j++) begin
            tick();
            if (j < 4) check({tag, " verify_busy"}, 32'(outs), 32'(7'b0011100));
            else       check({tag, " end_outs"}, 32'(outs), 32'(exp_end));
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        rst_n = 1'b0; start = 1'b0; length = 11'd0; in_data = 8'h5A; in_valid = 1'b1;

        // Reset held 3 cycles with in_valid high.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_outs", 32'(outs), 32'd0);
            check("reset_addr", 32'(mem_addr), 32'd0);
            check("reset_data", 32'(mem_data), 32'd0);
        end
        check("reset_no_write", 32'(wr_count), 32'd0);
        rst_n = 1'b1; in_valid = 1'b0;
        tick();

        // Normal load: 0x11..0x44, sum 0xAA, read-back matches.
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
        wr_base = wr_count;
        load4(7'b0000010, "normal");
        check("normal_writes", 32'(wr_count - wr_base), 32'd4);
        for (int i = 0; i < 4; i++) check("normal_mem", 32'(mem[i]), 32'(pat[i]));

        // Gapped stream: 2 idle cycles between bytes.
        wr_base = wr_count;
        pat[0] = 8'hA1; pat[1] = 8'hB2; pat[2] = 8'hC3;
        start = 1'b1; length = 11'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data = pat[i]; in_valid = 1'b1;
            #1;
            check("gap_ram_in", 32'(mem_ram_in), 32'd1);
            check("gap_addr", 32'(mem_addr), 32'(i));
            tick();
            if (i < 2) begin
                in_valid = 1'b0;
                for (int g = 0; g < 2; g++) begin
                    #1;
                    check("gap_no_write", 32'(mem_ram_in), 32'd0);
                    check("gap_addr_hold", 32'(mem_addr), 32'(i + 1));
                    tick();
                end
            end
        end
        in_valid = 1'b0;
        wait_end(10, timed_out);
        check("gap_timeout", 32'(timed_out), 32'd0);
        check("gap_end_outs", 32'(outs), 32'(7'b0000010));
        check("gap_writes", 32'(wr_count - wr_base), 32'd3);
        for (int i = 0; i < 3; i++) check("gap_mem", 32'(mem[i]), 32'(pat[i]));

        // Corruption: address 2 reads back as 0x00 -> sum 0x77 vs 0xAA.
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
        corrupt = 1'b1;
        load4(7'b0000001, "corrupt");
        corrupt = 1'b0;

        // length = 0 from ERROR: done from edge S, no writes.
        wr_base = wr_count;
        start = 1'b1; length = 11'd0; in_data = 8'h77; in_valid = 1'b1;
        tick();
        start = 1'b0;
        check("len0_outs", 32'(outs), 32'(7'b0000010));
        tick(); tick();
        check("len0_outs_hold", 32'(outs), 32'(7'b0000010));
        check("len0_no_write", 32'(wr_count - wr_base), 32'd0);
        in_valid = 1'b0;

        // length = 1025: clamped to 1024 writes, no wrap.
        wr_base = wr_count;
        start = 1'b1; length = 11'd1025;
        tick();
        start = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            in_data = 8'(i); in_valid = 1'b1;
            tick();
        end
        in_data = 8'hEE;
        wait_end(2000, timed_out);
        check("big_timeout", 32'(timed_out), 32'd0);
        check("big_end_outs", 32'(outs), 32'(7'b0000010));
        check("big_writes", 32'(wr_count - wr_base), 32'd1024);
        check("big_last_addr", 32'(last_wr_addr), 32'd1023);
        check("big_mem0", 32'(mem[0]), 32'h00);
        check("big_mem1023", 32'(mem[1023]), 32'hFF);
        in_valid = 1'b0;

        // Abort after 2 of 4 bytes, then restart with length 2.
        wr_base = wr_count;
        start = 1'b1; length = 11'd4;
        tick();
        start = 1'b0;
        in_data = 8'hD0; in_valid = 1'b1; tick();
        in_data = 8'hD1; tick();
        in_data = 8'hD2; rst_n = 1'b0;
        #1;
        check("abort_no_write", 32'(mem_ram_in), 32'd0);
        tick();
        check("abort_outs", 32'(outs), 32'd0);
        check("abort_addr", 32'(mem_addr), 32'd0);
        rst_n = 1'b1; in_valid = 1'b0;
        tick();
        check("abort_writes", 32'(wr_count - wr_base), 32'd2);
        start = 1'b1; length = 11'd2;
        tick();
        start = 1'b0;
        in_data = 8'hE0; in_valid = 1'b1;
        #1;
        check("restart_addr0", 32'(mem_addr), 32'd0);
        tick();
        in_data = 8'hE1; tick();
        in_valid = 1'b0;
        wait_end(10, timed_out);
        check("restart_timeout", 32'(timed_out), 32'd0);
        check("restart_end_outs", 32'(outs), 32'(7'b0000010));
        check("restart_mem0", 32'(mem[0]), 32'hE0);
        check("restart_mem1", 32'(mem[1]), 32'hE1);
        check("restart_mem2_kept", 32'(mem[2]), 32'h02);
        check("restart_mem3_kept", 32'(mem[3]), 32'h03);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
